rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: host write FIFO depth in entries, minimum 1.
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive host-blocked cycles before a pipeline stall request, minimum 1.
REQ-003 Port clk  input  1  single clock, all state rising-edge.
REQ-004 Port clr  input  1  asynchronous, active-low reset.
REQ-005 Port wb_we  input  1  write-back stage register-write request.
REQ-006 Port wb_addr  input  5  write-back destination register.
REQ-007 Port wb_data  input  16  write-back data.
REQ-008 Port hlt  input  1  pipeline halted, no further write-back traffic.
REQ-009 Port stall_ack  input  1  pipeline frozen, write-back slot free.
REQ-010 Port host_valid  input  1  host write offered.
REQ-011 Port host_addr  input  5  host destination register.
REQ-012 Port host_data  input  16  host write data.
REQ-013 Port host_ready  output  1  host write accepted when valid and ready are both high.
REQ-014 Port host_err  output  1  one-cycle pulse, host write to register 0 rejected.
REQ-015 Port stall_req  output  1  request to freeze the pipeline for one host slot.
REQ-016 Port rf_we  output  1  register-file write enable.
REQ-017 Port rf_addr  output  5  register-file write address.
REQ-018 Port rf_data  output  16  register-file write data.

Function
REQ-019 host_ready SHALL be high exactly when FIFO count < DEPTH, independent of same-cycle pops; no pass-through at full.
REQ-020 An accepted host write with host_addr = 0 SHALL NOT be enqueued; host_err SHALL pulse high the following cycle.
REQ-021 Every cycle exactly one source SHALL be granted: wb_we = 1 wins; else FIFO non-empty pops the head entry; else none.
REQ-022 rf_we/rf_addr/rf_data SHALL be registered: the granted write appears one cycle after grant, rf_we high for exactly one cycle per write.
REQ-023 When no write is granted, rf_we SHALL be 0 and rf_addr/rf_data SHALL hold their previous values.
REQ-024 FIFO order SHALL be strict first-in first-out; push and pop in the same cycle SHALL leave count unchanged.
REQ-025 Starvation counter SHALL increment, saturating at STARVE_LIMIT, in each cycle the FIFO is non-empty and wb_we wins; it SHALL clear on every host pop.
REQ-026 FSM states NORMAL, STALL: NORMAL -> STALL when the counter reaches STARVE_LIMIT with the FIFO non-empty; stall_req SHALL be registered and high throughout STALL.
REQ-027 In STALL, a cycle with stall_ack = 1 and wb_we = 0 SHALL pop the host head, clear the counter, return to NORMAL; stall_req low the next cycle.
REQ-028 In STALL, wb_we = 1 SHALL still win regardless of stall_ack (in-flight instructions drain).
REQ-029 hlt = 1 SHALL force state NORMAL, clear the counter, and keep stall_req low; the FIFO drains at one entry per cycle.
REQ-030 Simultaneous host push and wb_we with an empty FIFO SHALL enqueue; the entry is eligible next cycle.

Reset
REQ-031 While clr = 0: rf_we, rf_addr, rf_data, stall_req, host_err, host_ready SHALL be 0; FIFO empty; counter 0; state NORMAL.
REQ-032 Reset asserted mid-operation SHALL discard all queued host writes without emitting them; host_ready rises the first cycle after clr releases.

Structure
REQ-033 Shared package rf_arb_pkg SHALL hold REG_ADDR_W = 5, DATA_W = 16, and the state enum {NORMAL, STALL}.
REQ-034 The host queue SHALL be a sub-module rf_host_fifo (DEPTH, push/pop/count, data and address together).

Verification
REQ-035 Idle pipeline, host writes r3 = 0x1234 -> rf_we one cycle later, rf_addr 3, rf_data 0x1234.
REQ-036 wb_we r5 = 0x00FF and host r6 = 0xBEEF same cycle -> r5 written first, r6 the following cycle.
REQ-037 wb_we held high 8 cycles, one queued host entry, STARVE_LIMIT 8 -> stall_req rises; stall_ack with wb_we low -> host entry written, stall_req falls next cycle.
REQ-038 DEPTH 2, three back-to-back host writes during continuous wb_we -> host_ready low after two; order preserved on drain.
REQ-039 Host write to r0 = 0xAAAA -> no rf_we, host_err pulses once.
REQ-040 Two entries queued, clr pulled low -> all outputs 0, entries never written after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared widths, arbiter state encoding and the queued host-write record
// for the register-file write arbiter.
package rf_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 16;

    typedef enum logic {
        NORMAL = 1'b0,
        STALL  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } rf_wr_t;
endpackage

// File: rtl/rf_host_fifo.sv
// Host write queue: DEPTH-entry circular buffer holding address and data together.
// The caller never pushes when full or pops when empty.
module rf_host_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         i_push,
    input  rf_wr_t                       i_wdata,
    input  logic                         i_pop,
    output rf_wr_t                       o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wr_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: write-back always wins, host writes are queued
// and drained in free slots, with a pipeline stall request when the host starves.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  hlt,
    input  logic                  stall_ack,
    input  logic                  host_valid,
    input  logic [REG_ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0]     host_data,
    output logic                  host_ready,
    output logic                  host_err,
    output logic                  stall_req,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0]     rf_data
);
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCNT_W-1:0] LIMIT = SCNT_W'(STARVE_LIMIT);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [SCNT_W-1:0]     r_starve;
    logic [SCNT_W-1:0]     w_starve_nxt;
    logic                  r_run;
    logic                  r_err;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0]     r_rf_data;
    logic [FCNT_W-1:0]     w_count;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    rf_wr_t                w_head;
    rf_wr_t                w_wdata;

    rf_host_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // r_run keeps host_ready low until the first edge after reset release.
    assign host_ready = r_run && (w_count < FCNT_W'(DEPTH));
    assign w_empty    = (w_count == '0);
    assign w_accept   = host_valid && host_ready;
    assign w_push     = w_accept && (host_addr != '0);
    assign w_pop      = !wb_we && !w_empty;
    assign w_wdata    = '{addr: host_addr, data: host_data};

    always_comb begin
        w_starve_nxt = r_starve;
        if (hlt || w_pop)
            w_starve_nxt = '0;
        else if (wb_we && !w_empty && (r_starve != LIMIT))
            w_starve_nxt = r_starve + SCNT_W'(1);
    end

    // STALL also ends if bubbles drain the queue before the pipeline acknowledges.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NORMAL:  if (!hlt && wb_we && !w_empty && (w_starve_nxt == LIMIT))
                         w_state_nxt = STALL;
            STALL:   if (hlt || w_empty || (stall_ack && !wb_we))
                         w_state_nxt = NORMAL;
            default: w_state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= NORMAL;
            r_starve <= '0;
            r_run    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_run    <= 1'b1;
            r_err    <= w_accept && (host_addr == '0);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= wb_we || w_pop;
            if (wb_we) begin
                r_rf_addr <= wb_addr;
                r_rf_data <= wb_data;
            end else if (w_pop) begin
                r_rf_addr <= w_head.addr;
                r_rf_data <= w_head.data;
            end
        end
    end

    assign host_err  = r_err;
    assign stall_req = (r_state == STALL);
    assign rf_we     = r_rf_we;
    assign rf_addr   = r_rf_addr;
    assign rf_data   = r_rf_data;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized bench for rf_wr_arbiter against a queue-based reference model,
// preceded by directed scenarios with hand-computed expectations.
module tb_rf_wr_arbiter;
    localparam int DEPTH = 2;
    localparam int LIM   = 8;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        wb_we = 1'b0, hlt = 1'b0, stall_ack = 1'b0, host_valid = 1'b0;
    logic [4:0]  wb_addr = '0, host_addr = '0;
    logic [15:0] wb_data = '0, host_data = '0;
    logic        host_ready, host_err, stall_req, rf_we;
    logic [4:0]  rf_addr;
    logic [15:0] rf_data;

    int n_cmp = 0;
    int n_bad = 0;

    rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .clr(clr), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .hlt(hlt), .stall_ack(stall_ack), .host_valid(host_valid),
        .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
        .host_err(host_err), .stall_req(stall_req), .rf_we(rf_we),
        .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: host queue, starvation count, stall flag, expected outputs.
    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } ent_t;
    ent_t        q[$];
    int          m_cnt = 0;
    bit          m_stall = 0, m_we = 0, m_err = 0, m_run = 0;
    logic [4:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    bit          ne, rdy, acc, pop;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            q.delete();
            m_cnt = 0; m_stall = 0; m_we = 0; m_err = 0; m_run = 0;
            m_addr = '0; m_data = '0;
        end else begin
            ne  = q.size() > 0;
            rdy = m_run && (q.size() < DEPTH);
            acc = host_valid && rdy;
            pop = !wb_we && ne;
            m_we = wb_we || pop;
            if (wb_we) begin
                m_addr = wb_addr; m_data = wb_data;
            end else if (pop) begin
                m_addr = q[0].a; m_data = q[0].d;
            end
            if (hlt || pop) m_cnt = 0;
            else if (wb_we && ne) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
            if (hlt) m_stall = 0;
            else if (!m_stall) m_stall = wb_we && ne && (m_cnt >= LIM);
            else if ((stall_ack && !wb_we) || !ne) m_stall = 0;
            if (pop) void'(q.pop_front());
            if (acc && host_addr != 0) q.push_back('{a: host_addr, d: host_data});
            m_err = acc && (host_addr == 0);
            m_run = 1;
        end
    end

    always @(negedge clk) begin
        chk("host_ready", host_ready, m_run && (q.size() < DEPTH));
        chk("host_err", host_err, m_err);
        chk("stall_req", stall_req, m_stall);
        chk("rf_we", rf_we, m_we);
        chk("rf_addr", rf_addr, m_addr);
        chk("rf_data", rf_data, m_data);
    end

    initial begin
        #1 clr = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_stall_req", stall_req, 0);
        step(); step();
        clr = 1'b1;
        step();
        chk("ready_after_rst", host_ready, 1);

        // idle pipeline, host r3 = 0x1234
        host_valid = 1; host_addr = 5'd3; host_data = 16'h1234;
        step();
        host_valid = 0;
        chk("idle_no_early_we", rf_we, 0);
        step();
        chk("idle_we", rf_we, 1);
        chk("idle_addr", rf_addr, 3);
        chk("idle_data", rf_data, 16'h1234);
        step();
        chk("idle_we_drop", rf_we, 0);
        chk("idle_addr_hold", rf_addr, 3);

        // write-back and host in the same cycle
        wb_we = 1; wb_addr = 5'd5; wb_data = 16'h00FF;
        host_valid = 1; host_addr = 5'd6; host_data = 16'hBEEF;
        step();
        wb_we = 0; host_valid = 0;
        chk("coll_wb_addr", rf_addr, 5);
        chk("coll_wb_data", rf_data, 16'h00FF);
        step();
        chk("coll_host_we", rf_we, 1);
        chk("coll_host_addr", rf_addr, 6);
        chk("coll_host_data", rf_data, 16'hBEEF);
        step();

        // host write to r0 is rejected
        host_valid = 1; host_addr = 5'd0; host_data = 16'hAAAA;
        step();
        host_valid = 0;
        chk("r0_err", host_err, 1);
        chk("r0_we", rf_we, 0);
        step();
        chk("r0_err_pulse", host_err, 0);
        chk("r0_no_we", rf_we, 0);

        // starvation -> stall request -> acknowledged slot
        wb_we = 1; wb_addr = 5'd1; wb_data = 16'h0000;
        host_valid = 1; host_addr = 5'd7; host_data = 16'h5555;
        step();
        host_valid = 0;
        repeat (7) step();
        chk("starve_7", stall_req, 0);
        step();
        chk("starve_8", stall_req, 1);
        stall_ack = 1;
        step();
        chk("stall_wb_wins", rf_addr, 1);
        chk("stall_held", stall_req, 1);
        wb_we = 0;
        step();
        chk("stall_pop_addr", rf_addr, 7);
        chk("stall_pop_data", rf_data, 16'h5555);
        chk("stall_release", stall_req, 0);
        stall_ack = 0;

        // fill DEPTH=2 during continuous write-back, then drain in order
        wb_we = 1; wb_addr = 5'd2; wb_data = 16'h2222;
        host_valid = 1; host_addr = 5'd8; host_data = 16'h0008;
        step();
        chk("fill1_ready", host_ready, 1);
        host_addr = 5'd9; host_data = 16'h0009;
        step();
        chk("fill2_ready", host_ready, 0);
        host_addr = 5'd10; host_data = 16'h000A;
        step();
        chk("full_ready", host_ready, 0);
        wb_we = 0;
        step();
        chk("drain1_addr", rf_addr, 8);
        step();
        host_valid = 0;
        chk("drain2_addr", rf_addr, 9);
        step();
        chk("drain3_addr", rf_addr, 10);
        chk("drain3_data", rf_data, 16'h000A);
        step();

        // reset with two queued entries discards them
        wb_we = 1; wb_addr = 5'd4; wb_data = 16'h4444;
        host_valid = 1; host_addr = 5'd11; host_data = 16'h0B0B;
        step();
        host_addr = 5'd12; host_data = 16'h0C0C;
        step();
        host_valid = 0; wb_we = 0;
        clr = 1'b0;
        #1;
        chk("midrst_we", rf_we, 0);
        chk("midrst_addr", rf_addr, 0);
        chk("midrst_data", rf_data, 0);
        chk("midrst_ready", host_ready, 0);
        step();
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_no_we", rf_we, 0);
        end
        chk("post_rst_ready", host_ready, 1);

        // randomized phases: heavy write-back, mixed traffic, halt, resets
        for (int ph = 0; ph < 6; ph++) begin
            int pwb, phv, pack, phlt;
            pwb  = (ph % 2 == 0) ? 92 : int'($urandom_range(10, 60));
            phv  = int'($urandom_range(20, 80));
            pack = int'($urandom_range(5, 60));
            phlt = (ph == 3) ? 30 : 0;
            for (int c = 0; c < 400; c++) begin
                wb_we      = ($urandom_range(0, 99) < pwb);
                wb_addr    = 5'($urandom);
                wb_data    = 16'($urandom);
                host_valid = ($urandom_range(0, 99) < phv);
                host_addr  = 5'($urandom_range(0, 31));
                host_data  = 16'($urandom);
                stall_ack  = ($urandom_range(0, 99) < pack);
                hlt        = ($urandom_range(0, 99) < phlt);
                clr        = ($urandom_range(0, 249) != 0);
                step();
            end
        end
        clr = 1'b1; wb_we = 0; host_valid = 0; hlt = 0; stall_ack = 0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
